// File: rtl/mem_responder.sv
// Single-port word memory that answers one request at a time after WAIT_CYCLES wait states.
// Lets the CPU control FSM be exercised against non-zero memory latency.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshake: a request is taken at a rising edge where req_valid && req_ready;
  // req_ready is high only in S_IDLE and rsp_valid is a one-cycle pulse with no backpressure.
  state_t state;
  logic [3:0] wait_cnt;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  c_we;
  logic [ADDR_W-1:0]     c_addr;
  logic [DATA_W-1:0]     c_wdata;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;

  // With zero wait states the access happens on the accept edge, so the live request is used.
  always_comb begin
    accept     = (state == S_IDLE) && req_valid;
    enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd0));
    c_we       = (state == S_IDLE) ? req_we    : we_q;
    c_addr     = (state == S_IDLE) ? req_addr  : addr_q;
    c_wdata    = (state == S_IDLE) ? req_wdata : wdata_q;
    c_err      = (c_addr[1:0] != 2'b00) || (c_addr[ADDR_W-1:DEPTH_LOG2+2] != '0);
    c_idx      = c_addr[DEPTH_LOG2+1:2];
  end

  // Array is deliberately not reset; a store is dropped if rst lands on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && c_we && !c_err) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (enter_resp) begin
      err_q <= c_err;
      rd_q  <= (c_err || c_we) ? '0 : mem[c_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_q;
          rsp_err   <= err_q;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_responder;

  localparam int WC0 = 2;
  localparam int WC1 = 0;
  localparam int NWORDS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(WC0)) u_dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(WC1)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit sb_en = 1'b0;
  int pulse_cnt [2];
  logic [31:0] exp_q [$];

  // transaction-level model state
  bit          m_pend  [2];
  int          m_cmt   [2];
  int          m_pls   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_res   [2];
  logic        m_rerr  [2];
  logic [31:0] m_mem   [2][NWORDS];
  logic        e_ready [2];
  logic        e_busy  [2];
  logic        e_valid [2];
  logic        e_err   [2];
  logic [31:0] e_rdata [2];

  function automatic int wc_of(input int k);
    return (k == 0) ? WC0 : WC1;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] pre_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic void chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL d%0d %s got=%0h exp=%0h t=%0t", k, nm, got, exp, $time);
    end
  endfunction

  function automatic void fail_line(input int k, input string nm);
    vectors++;
    miscompares++;
    $display("FAIL d%0d %s got=timeout exp=event t=%0t", k, nm, $time);
  endfunction

  // Accepted request: data effect at edge accept+W, response visible after edge accept+W+1.
  function automatic void model_step(input int k);
    if (rst[k]) begin
      m_pend[k]  = 1'b0;
      e_valid[k] = 1'b0;
      e_rdata[k] = '0;
      e_err[k]   = 1'b0;
    end else begin
      e_valid[k] = 1'b0;
      if (!m_pend[k] && req_valid[k]) begin
        m_pend[k]  = 1'b1;
        m_we[k]    = req_we[k];
        m_addr[k]  = req_addr[k];
        m_wdata[k] = req_wdata[k];
        m_cmt[k]   = cyc + wc_of(k);
        m_pls[k]   = cyc + wc_of(k) + 1;
      end
      if (m_pend[k] && cyc == m_cmt[k]) begin
        m_rerr[k] = bad_addr(m_addr[k]);
        if (m_rerr[k]) begin
          m_res[k] = '0;
        end else if (m_we[k]) begin
          m_mem[k][m_addr[k] / 4] = m_wdata[k];
          m_res[k] = '0;
        end else begin
          m_res[k] = m_mem[k][m_addr[k] / 4];
        end
      end
      if (m_pend[k] && cyc == m_pls[k]) begin
        e_valid[k] = 1'b1;
        e_rdata[k] = m_res[k];
        e_err[k]   = m_rerr[k];
        m_pend[k]  = 1'b0;
      end
    end
    e_ready[k] = !m_pend[k];
    e_busy[k]  = m_pend[k];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; e_ready[k] = 1'b1; e_busy[k] = 1'b0;
      e_valid[k] = 1'b0; e_err[k] = 1'b0; e_rdata[k] = '0;
      m_res[k] = '0; m_rerr[k] = 1'b0; pulse_cnt[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      cyc++;
    end
  end

  // compare process and response monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk(k, "req_ready", 32'(req_ready[k]), 32'(e_ready[k]));
          chk(k, "busy",      32'(busy[k]),      32'(e_busy[k]));
          chk(k, "rsp_valid", 32'(rsp_valid[k]), 32'(e_valid[k]));
          chk(k, "rsp_err",   32'(rsp_err[k]),   32'(e_err[k]));
          chk(k, "rsp_rdata", rsp_rdata[k],      e_rdata[k]);
          if (rsp_valid[k] === 1'b1) pulse_cnt[k]++;
        end
        if (sb_en && rsp_valid[1] === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL d1 sb_extra got=pulse exp=none t=%0t", $time);
          end else begin
            chk(1, "sb_rdata", rsp_rdata[1], exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hold, output int acc);
    int n;
    n = 0;
    acc = -1;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
    while (req_ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[k] !== 1'b1) begin
      fail_line(k, "issue_ready");
      req_valid[k] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc - 1;
      if (!hold) req_valid[k] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int k, input int start, output logic [31:0] d, output logic e, output int lat);
    int i;
    i = start;
    lat = -1; d = '0; e = 1'b0;
    while (i < start + 40) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) begin
        d = rsp_rdata[k]; e = rsp_err[k]; lat = i;
        break;
      end
      i++;
    end
    if (lat < 0) fail_line(k, "wait_rsp");
  endtask

  task automatic do_req(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] d, output logic e, output int lat);
    int acc;
    issue(k, we, addr, wdata, 1'b0, acc);
    wait_rsp(k, 0, d, e, lat);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, a0, a1, a2, p;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) rst[k] = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_ready", 32'(req_ready[k]), 32'd1);
      chk(k, "rst_busy",  32'(busy[k]),      32'd0);
      chk(k, "rst_valid", 32'(rsp_valid[k]), 32'd0);
      chk(k, "rst_err",   32'(rsp_err[k]),   32'd0);
    end

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        do_req(k, 1'b1, 32'(i * 4), pre_val(i), d, e, lat);
        chk(k, "pre_lat", 32'(lat), 32'(wc_of(k) + 1));
      end
    end

    // 2 wait states: store then read back
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, d, e, lat);
    chk(0, "t2_lat", 32'(lat), 32'd3);
    chk(0, "t2_err", 32'(e), 32'd0);
    do_req(0, 1'b0, 32'h10, '0, d, e, lat);
    chk(0, "t2_rdata", d, 32'hDEADBEEF);

    // rejected accesses
    do_req(0, 1'b0, 32'h13, '0, d, e, lat);
    chk(0, "t4_mis_err", 32'(e), 32'd1);
    chk(0, "t4_mis_data", d, 32'd0);
    do_req(0, 1'b0, 32'h400, '0, d, e, lat);
    chk(0, "t4_oor_err", 32'(e), 32'd1);
    chk(0, "t4_oor_data", d, 32'd0);
    do_req(0, 1'b1, 32'h402, 32'h55, d, e, lat);
    chk(0, "t4_st_err", 32'(e), 32'd1);
    do_req(0, 1'b0, 32'h0, '0, d, e, lat);
    chk(0, "t4_word0", d, 32'hC0DE0000);
    chk(0, "t4_word0_err", 32'(e), 32'd0);

    // reset while waiting abandons the store and the pulse
    p = pulse_cnt[0];
    issue(0, 1'b1, 32'h20, 32'h1234, 1'b0, a0);
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk(0, "t5_no_pulse", 32'(pulse_cnt[0]), 32'(p));
    chk(0, "t5_busy", 32'(busy[0]), 32'd0);
    do_req(0, 1'b0, 32'h20, '0, d, e, lat);
    chk(0, "t5_old", d, 32'hC0DE0008);

    // request while busy is ignored
    p = pulse_cnt[0];
    issue(0, 1'b0, 32'h4, '0, 1'b0, a0);
    @(negedge clk); req_valid[0] = 1'b1; req_addr[0] = 32'h8; req_we[0] = 1'b0;
    @(negedge clk); req_valid[0] = 1'b0;
    wait_rsp(0, 2, d, e, lat);
    chk(0, "t6_rdata", d, 32'hC0DE0001);
    chk(0, "t6_lat", 32'(lat), 32'd3);
    repeat (6) @(negedge clk);
    chk(0, "t6_pulses", 32'(pulse_cnt[0] - p), 32'd1);

    // zero wait states, back-to-back with req_valid held
    p = pulse_cnt[1];
    sb_en = 1'b1;
    exp_q.push_back(32'hC0DE0000);
    exp_q.push_back(32'hC0DE0001);
    exp_q.push_back(32'hC0DE0002);
    issue(1, 1'b0, 32'h0, '0, 1'b1, a0);
    issue(1, 1'b0, 32'h4, '0, 1'b1, a1);
    issue(1, 1'b0, 32'h8, '0, 1'b0, a2);
    repeat (6) @(negedge clk);
    sb_en = 1'b0;
    chk(1, "t3_gap1", 32'(a1 - a0), 32'd2);
    chk(1, "t3_gap2", 32'(a2 - a1), 32'd2);
    chk(1, "t3_sb_left", 32'(exp_q.size()), 32'd0);
    chk(1, "t3_pulses", 32'(pulse_cnt[1] - p), 32'd3);
    do_req(1, 1'b0, 32'h13, '0, d, e, lat);
    chk(1, "t4_w0_err", 32'(e), 32'd1);
    chk(1, "t4_w0_lat", 32'(lat), 32'd1);

    // randomized traffic, checked cycle by cycle by the model
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 120; n++) begin
        int r, w, act;
        logic [31:0] a;
        logic we;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, 15);
        if (r == 0) a = 32'(w * 4) + 32'($urandom_range(1, 3));
        else if (r == 1) a = (32'd1 << $urandom_range(10, 31)) | 32'(w * 4);
        else a = 32'(w * 4);
        we = 1'($urandom_range(0, 1));
        act = $urandom_range(0, 9);
        issue(k, we, a, $urandom, 1'b0, a0);
        if (act == 0) begin
          repeat ($urandom_range(0, wc_of(k) + 1)) @(negedge clk);
          rst[k] = 1'b1;
          @(negedge clk);
          rst[k] = 1'b0;
        end else if (act == 1 && k == 0) begin
          @(negedge clk);
          req_valid[k] = 1'b1; req_addr[k] = 32'($urandom_range(0, 15) * 4); req_we[k] = 1'b1;
          @(negedge clk);
          req_valid[k] = 1'b0;
          wait_rsp(k, 2, d, e, lat);
        end else begin
          wait_rsp(k, 0, d, e, lat);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
